// File: rtl/cache_read_ctrl.sv
// Cache read controller.
// Handles one read at a time: a hit returns cache data two cycles after the
// request is presented, and a miss writes back a dirty victim (if needed),
// fetches the line from RAM and fills the chosen way.
module cache_read_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rden,
    input  logic [6:0] address,
    input  logic [3:0] hit,
    input  logic [3:0] valido,
    input  logic [3:0] dirty,
    input  logic [3:0] lruBit,
    input  logic [7:0] cacheRdData,
    input  logic [7:0] victimData,
    input  logic [6:0] victimAddress,
    input  logic       ramAck,
    input  logic [7:0] ramRdData,
    output logic       ramRden,
    output logic       ramWren,
    output logic [6:0] ramAddress,
    output logic [7:0] ramWrData,
    output logic [3:0] fillWren,
    output logic [7:0] fillData,
    output logic       ready,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic [7:0] missCount
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WBACK,
        FILL,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [6:0] addr_q;
    logic [3:0] way_q;
    logic [6:0] victim_addr_q;
    logic [7:0] victim_data_q;
    logic [7:0] fill_data_q;
    logic [7:0] data_out_q;
    logic       hit_valid_q;
    logic [7:0] miss_count_q;

    logic [3:0] way_pick;
    logic       need_wback;

    // Victim choice: first invalid way wins; with every way valid, the lowest
    // set LRU bit wins; an all-zero LRU vector falls back to way 0.
    function automatic logic [3:0] pick_way(input logic [3:0] valid, input logic [3:0] lru);
        logic [3:0] way;
        way = 4'b0001;
        if (valid != 4'b1111) begin
            for (int i = 3; i >= 0; i--) begin
                if (!valid[i]) begin
                    way    = '0;
                    way[i] = 1'b1;
                end
            end
        end else if (lru != 4'b0000) begin
            for (int i = 3; i >= 0; i--) begin
                if (lru[i]) begin
                    way    = '0;
                    way[i] = 1'b1;
                end
            end
        end
        return way;
    endfunction

    assign way_pick   = pick_way(valido, lruBit);
    // Only a line that is both valid and dirty must be written back first.
    assign need_wback = |(way_pick & valido & dirty);

    assign dataOut    = data_out_q;
    assign missCount  = miss_count_q;

    // State register; reset aborts any transaction in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state and output decode; outputs depend on state and registers only.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        ramRden    = 1'b0;
        ramWren    = 1'b0;
        ramAddress = '0;
        ramWrData  = '0;
        fillWren   = '0;
        fillData   = '0;
        dataValid  = hit_valid_q;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (rden) state_next = CHECK;
            end
            CHECK: begin
                if (hit != 4'b0000)  state_next = IDLE;
                else if (need_wback) state_next = WBACK;
                else                 state_next = FILL;
            end
            WBACK: begin
                ramWren    = 1'b1;
                ramAddress = victim_addr_q;
                ramWrData  = victim_data_q;
                if (ramAck) state_next = FILL;
            end
            FILL: begin
                ramRden    = 1'b1;
                ramAddress = addr_q;
                if (ramAck) state_next = DONE;
            end
            DONE: begin
                fillWren   = way_q;
                fillData   = fill_data_q;
                dataValid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: request address, victim info, fill data, hit pulse, miss count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q        <= '0;
            way_q         <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            fill_data_q   <= '0;
            data_out_q    <= '0;
            hit_valid_q   <= 1'b0;
            miss_count_q  <= '0;
        end else begin
            hit_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rden) addr_q <= address;
                end
                CHECK: begin
                    if (hit != 4'b0000) begin
                        data_out_q  <= cacheRdData;
                        hit_valid_q <= 1'b1;
                    end else begin
                        miss_count_q <= miss_count_q + 8'd1;
                        way_q        <= way_pick;
                        if (need_wback) begin
                            victim_addr_q <= victimAddress;
                            victim_data_q <= victimData;
                        end
                    end
                end
                FILL: begin
                    if (ramAck) begin
                        fill_data_q <= ramRdData;
                        data_out_q  <= ramRdData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_read_ctrl.sv
// Directed testbench for cache_read_ctrl: hit, miss paths, reset abort, counter wrap.
module tb_cache_read_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       rden;
    logic [6:0] address;
    logic [3:0] hit, valido, dirty, lruBit;
    logic [7:0] cacheRdData, victimData;
    logic [6:0] victimAddress;
    logic       ramAck;
    logic [7:0] ramRdData;
    logic       ramRden, ramWren;
    logic [6:0] ramAddress;
    logic [7:0] ramWrData;
    logic [3:0] fillWren;
    logic [7:0] fillData;
    logic       ready;
    logic [7:0] dataOut;
    logic       dataValid;
    logic [7:0] missCount;

    int total = 0;
    int bad   = 0;

    cache_read_ctrl dut (
        .clock        (clock),
        .resetn       (resetn),
        .rden         (rden),
        .address      (address),
        .hit          (hit),
        .valido       (valido),
        .dirty        (dirty),
        .lruBit       (lruBit),
        .cacheRdData  (cacheRdData),
        .victimData   (victimData),
        .victimAddress(victimAddress),
        .ramAck       (ramAck),
        .ramRdData    (ramRdData),
        .ramRden      (ramRden),
        .ramWren      (ramWren),
        .ramAddress   (ramAddress),
        .ramWrData    (ramWrData),
        .fillWren     (fillWren),
        .fillData     (fillData),
        .ready        (ready),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .missCount    (missCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; land 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check all strobes idle and controller ready.
    task automatic check_quiet(input string tag);
        check({tag, ".ready"},    32'(ready),    32'd1);
        check({tag, ".ramRden"},  32'(ramRden),  32'd0);
        check({tag, ".ramWren"},  32'(ramWren),  32'd0);
        check({tag, ".fillWren"}, 32'(fillWren), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; rden = 1'b0; address = '0;
        hit = '0; valido = '0; dirty = '0; lruBit = '0;
        cacheRdData = '0; victimData = '0; victimAddress = '0;
        ramAck = 1'b0; ramRdData = '0;

        // Reset state
        tick(); tick();
        check_quiet("rst");
        check("rst.dataValid", 32'(dataValid), 32'd0);
        check("rst.dataOut",   32'(dataOut),   32'd0);
        check("rst.missCount", 32'(missCount), 32'd0);
        check("rst.ramAddress", 32'(ramAddress), 32'd0);
        resetn = 1'b1;
        tick();

        // Hit: 0x12, way 2, data A5
        rden = 1'b1; address = 7'h12;
        tick();
        rden = 1'b0; hit = 4'b0100; cacheRdData = 8'hA5;
        check("hit.busy", 32'(ready), 32'd0);
        tick();
        check("hit.dataValid", 32'(dataValid), 32'd1);
        check("hit.dataOut",   32'(dataOut),   32'hA5);
        check_quiet("hit");
        check("hit.missCount", 32'(missCount), 32'd0);
        hit = '0; cacheRdData = 8'h00;
        tick();
        check("hit.pulse_end", 32'(dataValid), 32'd0);
        check("hit.hold",      32'(dataOut),   32'hA5);

        // Miss to an invalid way: valido=0011 -> way 2, no writeback
        valido = 4'b0011; dirty = 4'b0011; lruBit = 4'b0001;
        rden = 1'b1; address = 7'h21;
        tick();
        rden = 1'b0;
        tick();
        check("inv.ramRden",    32'(ramRden),    32'd1);
        check("inv.ramWren",    32'(ramWren),    32'd0);
        check("inv.ramAddress", 32'(ramAddress), 32'h21);
        check("inv.missCount",  32'(missCount),  32'd1);
        tick();
        check("inv.hold_fill",  32'(ramRden),    32'd1);
        ramAck = 1'b1; ramRdData = 8'h3C;
        tick();
        ramAck = 1'b0; ramRdData = 8'h00;
        check("inv.fillWren",  32'(fillWren),  32'b0100);
        check("inv.fillData",  32'(fillData),  32'h3C);
        check("inv.dataOut",   32'(dataOut),   32'h3C);
        check("inv.dataValid", 32'(dataValid), 32'd1);
        check("inv.ramRden_off", 32'(ramRden), 32'd0);
        tick();
        check_quiet("inv.end");
        check("inv.dataValid_end", 32'(dataValid), 32'd0);
        check("inv.dataOut_hold",  32'(dataOut),   32'h3C);

        // Miss with dirty LRU victim in way 3
        valido = 4'b1111; lruBit = 4'b1000; dirty = 4'b1000;
        victimAddress = 7'h55; victimData = 8'hEE;
        rden = 1'b1; address = 7'h40;
        tick();
        rden = 1'b0;
        tick();
        check("dirty.ramWren",    32'(ramWren),    32'd1);
        check("dirty.ramRden",    32'(ramRden),    32'd0);
        check("dirty.ramAddress", 32'(ramAddress), 32'h55);
        check("dirty.ramWrData",  32'(ramWrData),  32'hEE);
        check("dirty.missCount",  32'(missCount),  32'd2);
        victimAddress = 7'h00; victimData = 8'h00;
        rden = 1'b1;   // ignored while busy
        tick();
        check("dirty.hold_addr", 32'(ramAddress), 32'h55);
        check("dirty.hold_data", 32'(ramWrData),  32'hEE);
        check("dirty.busy",      32'(ready),      32'd0);
        rden = 1'b0;
        ramAck = 1'b1;
        tick();
        ramAck = 1'b0;
        check("dirty.fill_rden",  32'(ramRden),    32'd1);
        check("dirty.fill_wren",  32'(ramWren),    32'd0);
        check("dirty.fill_addr",  32'(ramAddress), 32'h40);
        ramAck = 1'b1; ramRdData = 8'h77;
        tick();
        ramAck = 1'b0;
        check("dirty.fillWren", 32'(fillWren), 32'b1000);
        check("dirty.dataOut",  32'(dataOut),  32'h77);
        tick();
        check_quiet("dirty.end");
        tick();
        check("dirty.not_queued", 32'(ready), 32'd1);

        // Miss with clean LRU victim in way 1 (other ways dirty)
        valido = 4'b1111; lruBit = 4'b0010; dirty = 4'b1101;
        rden = 1'b1; address = 7'h0A;
        tick();
        rden = 1'b0;
        tick();
        check("clean.ramWren",   32'(ramWren),   32'd0);
        check("clean.ramRden",   32'(ramRden),   32'd1);
        check("clean.missCount", 32'(missCount), 32'd3);
        ramAck = 1'b1; ramRdData = 8'h5A;
        tick();
        ramAck = 1'b0;
        check("clean.fillWren", 32'(fillWren), 32'b0010);
        check("clean.fillData", 32'(fillData), 32'h5A);
        tick();

        // Reset in the middle of FILL
        valido = 4'b0000; dirty = 4'b0000;
        rden = 1'b1; address = 7'h33;
        tick();
        rden = 1'b0;
        tick();
        check("rfill.ramRden",   32'(ramRden),   32'd1);
        check("rfill.missCount", 32'(missCount), 32'd4);
        #2 resetn = 1'b0;
        #1;
        check_quiet("rfill.async");
        check("rfill.missCount0", 32'(missCount),  32'd0);
        check("rfill.dataOut0",   32'(dataOut),    32'd0);
        check("rfill.ramAddress", 32'(ramAddress), 32'd0);
        ramAck = 1'b1; ramRdData = 8'hF0;
        tick();
        resetn = 1'b1;
        tick();
        check_quiet("rfill.ack_ignored");
        check("rfill.no_valid", 32'(dataValid), 32'd0);
        check("rfill.dataOut",  32'(dataOut),   32'd0);
        ramAck = 1'b0; ramRdData = 8'h00;

        // First request after reset accepted on the next edge; multi-bit hit
        rden = 1'b1; address = 7'h01;
        tick();
        rden = 1'b0; hit = 4'b1111; cacheRdData = 8'hC3;
        check("post.accept", 32'(ready), 32'd0);
        tick();
        check("multi.dataValid", 32'(dataValid), 32'd1);
        check("multi.dataOut",   32'(dataOut),   32'hC3);
        check("multi.fillWren",  32'(fillWren),  32'd0);
        check("multi.missCount", 32'(missCount), 32'd0);
        hit = '0;
        tick();

        // 256 misses: all valid, LRU zero -> way 0, counter wraps
        valido = 4'b1111; lruBit = 4'b0000; dirty = 4'b0000;
        ramRdData = 8'h11;
        for (int i = 0; i < 255; i++) begin
            rden = 1'b1; address = 7'(i);
            tick();
            rden = 1'b0;
            tick();
            ramAck = 1'b1;
            tick();
            ramAck = 1'b0;
            tick();
        end
        check("wrap.count255", 32'(missCount), 32'd255);
        rden = 1'b1; address = 7'h7F;
        tick();
        rden = 1'b0;
        tick();
        check("wrap.count0", 32'(missCount), 32'd0);
        check("wrap.no_wb",  32'(ramWren),   32'd0);
        ramAck = 1'b1; ramRdData = 8'h42;
        tick();
        ramAck = 1'b0;
        check("wrap.fillWren", 32'(fillWren), 32'b0001);
        check("wrap.dataOut",  32'(dataOut),  32'h42);
        tick();
        check_quiet("wrap.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_read_ctrl.md
CACHE_READ_CTRL -- requirements
Module: cache_read_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state changes on posedge.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: rden  input  1  read request, sampled only when ready=1.
REQ-004 SHALL have port: address  input  7  read address, latched on accept.
REQ-005 SHALL have ports: hit, valido, dirty, lruBit  input  4 each  per-way tag hit, valid, dirty, LRU victim (one-hot).
REQ-006 SHALL have ports: cacheRdData, victimData  input  8 each  hit-way data; chosen-victim data.
REQ-007 SHALL have port: victimAddress  input  7  RAM address of the chosen victim line.
REQ-008 SHALL have ports: ramAck  input  1  RAM done; ramRdData  input  8  RAM read data, valid with ramAck.
REQ-009 SHALL have ports: ramRden, ramWren  output  1 each; ramAddress  output  7; ramWrData  output  8.
REQ-010 SHALL have ports: fillWren  output  4  one-hot cache-way write strobe; fillData  output  8.
REQ-011 SHALL have ports: ready  output  1  idle; dataOut  output  8; dataValid  output  1  one-cycle pulse.
REQ-012 SHALL have port: missCount  output  8  miss counter.

Function
REQ-013 SHALL implement states IDLE, CHECK, WBACK, FILL, DONE; ready=1 only in IDLE.
REQ-014 IDLE: rden=1 -> latch address, go CHECK; rden=0 -> stay.
REQ-015 CHECK: sample hit, valido, dirty, lruBit, cacheRdData, victimAddress, victimData this cycle (1-cycle cache read latency).
REQ-016 CHECK with hit!=0: dataOut<=cacheRdData, dataValid=1 next cycle, go IDLE; total latency 2 cycles from accept.
REQ-017 CHECK with hit=0: missCount+1 (wraps 255->0); register chosen way.
REQ-018 Way choice: lowest-index way with valido=0; if valido=4'b1111, lowest set bit of lruBit; lruBit=0 -> way 0.
REQ-019 After choice: chosen way valid AND dirty -> WBACK (latch victimAddress, victimData); else -> FILL.
REQ-020 WBACK: ramWren=1, ramAddress=victim address, ramWrData=victim data, held until ramAck=1, then FILL.
REQ-021 FILL: ramRden=1, ramAddress=latched address, held until ramAck=1; capture ramRdData; go DONE.
REQ-022 DONE (1 cycle): fillWren=chosen one-hot, fillData=captured data, dataOut=captured data, dataValid=1; go IDLE.
REQ-023 ramRden and ramWren SHALL never be 1 simultaneously; both 0 outside FILL/WBACK.
REQ-024 ramAck outside WBACK/FILL SHALL be ignored; rden while ready=0 SHALL be ignored (not queued).
REQ-025 fillWren SHALL be 0 except in DONE; never asserted on a hit.
REQ-026 dataOut SHALL hold its last value between pulses.
REQ-027 hit with more than one bit set: treated as hit; cacheRdData returned.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, ready=1, all other outputs and missCount to 0, latched registers to 0, regardless of state.
REQ-029 Reset mid-WBACK or mid-FILL SHALL abort the transaction; no fillWren or dataValid follows.
REQ-030 After resetn rises, first rden SHALL be accepted on the next posedge.

Verification
REQ-031 Hit: rden, address=7'h12, hit=4'b0100, cacheRdData=8'hA5 in CHECK -> dataValid with dataOut=8'hA5 2 cycles after accept; no RAM strobes; missCount=0.
REQ-032 Miss, invalid way: hit=0, valido=4'b0011 -> no WBACK; ramRden with ramAddress=address; ramAck with ramRdData=8'h3C -> fillWren=4'b0100, fillData=dataOut=8'h3C; missCount=1.
REQ-033 Miss, dirty victim: valido=4'b1111, lruBit=4'b1000, dirty=4'b1000, victimAddress=7'h55, victimData=8'hEE -> ramWren, ramAddress=7'h55, ramWrData=8'hEE until ack; then FILL; fillWren=4'b1000.
REQ-034 Miss, clean victim: valido=4'b1111, lruBit=4'b0010, dirty=0 -> no ramWren; FILL; fillWren=4'b0010.
REQ-035 Reset mid-FILL with ramAck pending -> all outputs 0, ready=1; later ramAck=1 has no effect.
REQ-036 rden pulsed during WBACK and 256 misses -> busy rden ignored; missCount wraps to 0.
